spectrum_peak_analyzer: RTL and testbench

SPECTRUM_PEAK_ANALYZER -- requirements
Module: spectrum_peak_analyzer

---
 rtl/fas_pkg.sv | 13 +
 rtl/cplx_mag_sq.sv | 22 ++
 rtl/spectrum_peak_analyzer.sv | 109 ++++++++++
 tb/tb_spectrum_peak_analyzer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared definitions for the spectrum peak analyzer: FSM states and default geometry.
package fas_pkg;

  localparam int FAS_DW     = 16;
  localparam int FAS_N_BINS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REPORT
  } fas_state_e;

endpackage

// File: rtl/cplx_mag_sq.sv
// Combinational squared magnitude of one complex bin word {re, im}.
module cplx_mag_sq #(
  parameter int DW = 16
) (
  input  logic [2*DW-1:0] bin,
  output logic [2*DW-1:0] mag
);

  logic signed [2*DW-1:0] re_x;
  logic signed [2*DW-1:0] im_x;
  logic signed [2*DW-1:0] re_sq;
  logic signed [2*DW-1:0] im_sq;

  assign re_x  = {{DW{bin[2*DW-1]}}, bin[2*DW-1:DW]};
  assign im_x  = {{DW{bin[DW-1]}}, bin[DW-1:0]};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  // Each square is at most 2^(2DW-2), so the unsigned sum cannot wrap.
  assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/spectrum_peak_analyzer.sv
// Latches one FFT frame, scans a bin range one bin per cycle and reports the strongest bin.
module spectrum_peak_analyzer
  import fas_pkg::*;
#(
  parameter  int N_BINS = FAS_N_BINS,
  parameter  int DW     = FAS_DW,
  localparam int IW     = $clog2(N_BINS),
  localparam int MAG_W  = 2 * DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_BINS*2*DW-1:0]   in_d,
  input  logic                     cfg_skip_dc,
  input  logic                     cfg_half,
  input  logic [MAG_W-1:0]         threshold,
  output logic                     done,
  output logic [IW-1:0]            freq,
  output logic [MAG_W-1:0]         peak_mag,
  output logic                     peak_found
);

  fas_state_e state, state_nxt;

  logic [2*DW-1:0]  bank [N_BINS];
  logic             half_q;
  logic [MAG_W-1:0] thr_q;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    scan_end;
  logic [IW-1:0]    max_idx;
  logic [MAG_W-1:0] max_mag;
  logic [MAG_W-1:0] bin_mag;
  logic [IW-1:0]    cand_idx;
  logic [MAG_W-1:0] cand_mag;
  logic             accept;
  logic             last_bin;

  assign in_ready = (state == ST_IDLE);
  assign done     = (state == ST_REPORT);
  assign accept   = in_valid && in_ready;
  assign scan_end = half_q ? IW'(N_BINS / 2 - 1) : IW'(N_BINS - 1);
  assign last_bin = (idx == scan_end);

  cplx_mag_sq #(.DW(DW)) u_mag (
    .bin (bank[idx]),
    .mag (bin_mag)
  );

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    cand_mag = max_mag;
    cand_idx = max_idx;
    if (bin_mag > max_mag) begin
      cand_mag = bin_mag;
      cand_idx = idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SCAN;
      ST_SCAN:   if (last_bin) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_BINS; i++) bank[i] <= '0;
      half_q     <= 1'b0;
      thr_q      <= '0;
      idx        <= '0;
      max_idx    <= '0;
      max_mag    <= '0;
      freq       <= '0;
      peak_mag   <= '0;
      peak_found <= 1'b0;
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < N_BINS; i++) bank[i] <= in_d[i*2*DW +: 2*DW];
        half_q  <= cfg_half;
        thr_q   <= threshold;
        idx     <= cfg_skip_dc ? IW'(1) : '0;
        max_idx <= cfg_skip_dc ? IW'(1) : '0;
        max_mag <= '0;
      end else if (state == ST_SCAN) begin
        max_mag <= cand_mag;
        max_idx <= cand_idx;
        if (last_bin) begin
          // Results land on the edge entering REPORT so they are valid while done is high.
          freq       <= cand_idx;
          peak_mag   <= cand_mag;
          peak_found <= (cand_mag > thr_q);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_analyzer.sv
// Directed and randomized frames checked against an arithmetic peak-search model.
module tb_spectrum_peak_analyzer;

  localparam int NB = 16;
  localparam int DW = 16;
  localparam int MW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [NB*2*DW-1:0] in_d = '0;
  logic             cfg_skip_dc = 1'b0;
  logic             cfg_half = 1'b0;
  logic [MW-1:0]    threshold = '0;
  logic             done;
  logic [3:0]       freq;
  logic [MW-1:0]    peak_mag;
  logic             peak_found;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  logic signed [DW-1:0] re_a [NB];
  logic signed [DW-1:0] im_a [NB];

  spectrum_peak_analyzer #(.N_BINS(NB), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_d        (in_d),
    .cfg_skip_dc (cfg_skip_dc),
    .cfg_half    (cfg_half),
    .threshold   (threshold),
    .done        (done),
    .freq        (freq),
    .peak_mag    (peak_mag),
    .peak_found  (peak_found)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void clear_bins();
    for (int k = 0; k < NB; k++) begin
      re_a[k] = '0;
      im_a[k] = '0;
    end
  endfunction

  function automatic void pack_bins();
    for (int k = 0; k < NB; k++) in_d[k*2*DW +: 2*DW] = {re_a[k], im_a[k]};
  endfunction

  task automatic model(input bit skip, input bit half, output int f, output longint m);
    int s, e;
    longint v;
    s = skip ? 1 : 0;
    e = half ? NB/2 - 1 : NB - 1;
    m = 0;
    f = s;
    for (int k = s; k <= e; k++) begin
      v = longint'(re_a[k]) * longint'(re_a[k]) + longint'(im_a[k]) * longint'(im_a[k]);
      if (v > m) begin
        m = v;
        f = k;
      end
    end
  endtask

  task automatic scramble_inputs();
    for (int w = 0; w < NB; w++) in_d[w*32 +: 32] = $urandom();
    threshold   = $urandom();
    cfg_skip_dc = 1'($urandom_range(0, 1));
    cfg_half    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int budget, input bit scramble, output int j, output bit ok);
    j  = 0;
    ok = 1'b0;
    while (!ok && j < budget) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        if (scramble) scramble_inputs();
        @(negedge clk);
        j++;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge following the REPORT cycle.
  task automatic run_frame(input string tag, input bit skip, input bit half,
                           input logic [MW-1:0] thr, input bit scramble, input bit immediate);
    int f, s, e, j, cnt;
    longint m;
    bit ok;
    model(skip, half, f, m);
    s = skip ? 1 : 0;
    e = half ? NB/2 - 1 : NB - 1;
    pack_bins();
    cfg_skip_dc = skip;
    cfg_half    = half;
    threshold   = thr;
    in_valid    = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, ":ready"}, 64'(in_ready), 64'(1));
    if (immediate) check({tag, ":first_cycle_accept"}, 64'(cnt), 64'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(200, scramble, j, ok);
    check({tag, ":latency"}, ok ? 64'(j + 1) : 64'(-1), 64'(e - s + 2));
    check({tag, ":freq"}, 64'(freq), 64'(f));
    check({tag, ":peak_mag"}, 64'(peak_mag), 64'(m));
    check({tag, ":peak_found"}, 64'(peak_found), 64'(m > longint'({32'b0, thr})));
    @(negedge clk);
    check({tag, ":done_pulse"}, 64'(done), 64'(0));
    check({tag, ":freq_hold"}, 64'(freq), 64'(f));
  endtask

  initial begin
    int f, c1, c2, c3, j, mode, cnt, seen;
    longint m;
    bit ok, skip, half;
    logic [MW-1:0] thr;

    clear_bins();
    repeat (3) @(negedge clk);
    check("reset:in_ready", 64'(in_ready), 64'(1));
    check("reset:done", 64'(done), 64'(0));
    check("reset:freq", 64'(freq), 64'(0));
    check("reset:peak_mag", 64'(peak_mag), 64'(0));
    check("reset:peak_found", 64'(peak_found), 64'(0));
    rst = 1'b1;

    // 3-4-5 triangle at bin 5, inputs scrambled during the scan
    clear_bins(); re_a[5] = 3; im_a[5] = 4;
    run_frame("bin5", 1'b0, 1'b0, 32'd20, 1'b1, 1'b1);

    clear_bins(); re_a[2] = -6; re_a[9] = -6;
    run_frame("tie", 1'b0, 1'b0, 32'd36, 1'b0, 1'b0);

    clear_bins(); re_a[0] = 100; im_a[3] = 10;
    run_frame("skip_dc", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);

    clear_bins(); re_a[12] = 50; re_a[4] = 2;
    run_frame("half", 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);

    clear_bins(); re_a[7] = -32768; im_a[7] = -32768;
    run_frame("extreme", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    clear_bins();
    run_frame("zero", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      mode = $urandom_range(0, 2);
      clear_bins();
      for (int k = 0; k < NB; k++) begin
        if (mode == 0) begin
          re_a[k] = DW'($urandom());
          im_a[k] = DW'($urandom());
        end else if (mode == 1) begin
          re_a[k] = DW'(int'($urandom_range(0, 6)) - 3);
          im_a[k] = DW'(int'($urandom_range(0, 6)) - 3);
        end
      end
      if (mode == 2) re_a[$urandom_range(0, NB-1)] = DW'($urandom());
      skip = 1'($urandom_range(0, 1));
      half = 1'($urandom_range(0, 1));
      model(skip, half, f, m);
      thr = MW'(m + longint'($urandom_range(0, 2)) - 1);
      run_frame($sformatf("rand%0d", r), skip, half, thr, r[0], 1'b0);
    end

    // in_valid held high: one frame per 18 cycles
    clear_bins(); re_a[1] = 1; im_a[1] = 1;
    pack_bins();
    cfg_skip_dc = 1'b0; cfg_half = 1'b0; threshold = '0;
    in_valid = 1'b1;
    wait_done(100, 1'b0, j, ok);
    c1 = cyc;
    check("cont:done1", 64'(ok), 64'(1));
    @(negedge clk);
    wait_done(100, 1'b0, j, ok);
    c2 = cyc;
    check("cont:period1", 64'(c2 - c1), 64'(18));
    @(negedge clk);
    wait_done(100, 1'b0, j, ok);
    c3 = cyc;
    in_valid = 1'b0;
    check("cont:period2", 64'(c3 - c2), 64'(18));
    check("cont:freq", 64'(freq), 64'(1));
    check("cont:peak_mag", 64'(peak_mag), 64'(2));
    @(negedge clk);

    // reset in the middle of a scan aborts the frame
    clear_bins(); re_a[6] = 5; im_a[6] = 5;
    pack_bins();
    in_valid = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst:freq", 64'(freq), 64'(0));
    check("midrst:peak_mag", 64'(peak_mag), 64'(0));
    check("midrst:peak_found", 64'(peak_found), 64'(0));
    check("midrst:done", 64'(done), 64'(0));
    check("midrst:in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("midrst:no_done", 64'(seen), 64'(0));
    run_frame("after_rst", 1'b0, 1'b0, 32'd49, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
